// File: rtl/dmem_bridge_pkg.sv
// dmem_pkg: shared types and constants for the data-memory bridge.
// Holds the bus FSM states, the MMIO base/status layout and the
// posted-write FIFO entry format.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } busState_t;

    // Base of the MMIO window; also the status/clear register address.
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // Status word bit positions.
    localparam int ST_EMPTY      = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_BUSREQ     = 2;
    localparam int ST_COUNT_LSB  = 4;
    localparam int ST_OVFCNT_LSB = 8;

    localparam logic [7:0] OVFCNT_MAX = 8'hFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifoEntry_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: posted-write peripheral bus. The bridge is the master;
// the peripheral drives busAck to accept the presented head entry.
interface dmem_bridge_if;
    logic        busReq;
    logic [31:0] busAddr;
    logic [31:0] busData;
    logic        busAck;

    modport master (output busReq, output busAddr, output busData, input busAck);
    modport slave  (input busReq, input busAddr, input busData, output busAck);
endinterface

// File: rtl/dmem_bridge_fifo.sv
// sync_fifo: single-clock register FIFO. A push into a full FIFO is taken
// only when a pop happens in the same cycle (the freed head slot is the
// tail slot). Pointers wrap naturally because DEPTH is a power of 2.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wrPtrReg;
    logic [PW-1:0]    rdPtrReg;
    logic [PW:0]      countReg;
    logic [WIDTH-1:0] memReg [DEPTH];
    logic [DEPTH-1:0] wrEn;
    logic             doPush;
    logic             doPop;

    assign empty  = (countReg == '0);
    assign full   = (countReg == (PW+1)'(DEPTH));
    assign count  = countReg;
    assign dout   = memReg[rdPtrReg];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // One write enable per entry, decoded from the tail pointer.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wrEn
            assign wrEn[gi] = doPush && (wrPtrReg == PW'(gi));
        end
    endgenerate

    // Entry storage; cleared on reset so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) memReg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrEn[i]) memReg[i] <= din;
            end
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: core data-memory port split into a local RAM (addr[31]=0)
// and a posted-write MMIO window (addr[31]=1) drained over a req/ack bus.
// Store to MMIO_BASE clears the overflow state; load from it reads status.
// Optional: define DMEM_BRIDGE_OVFCNT_EN for the 8-bit saturating
// overflow counter reported in status bits [15:8].
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [31:0]         dmemAddr,
    input  logic [31:0]         dmemWdata,
    input  logic                dmemWen,
    output logic [31:0]         dmemRdata,
    dmem_bridge_if.master       bus,
    output logic                ovf
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ramMem [RAM_WORDS];
    logic [AW-1:0] ramIdx;
    logic          ramSel;
    logic          statusSel;
    logic          clrStore;
    logic          pushReq;
    logic          pushOk;
    logic          drop;
    logic          pop;
    logic          busReqInt;
    busState_t     stateReg;
    busState_t     stateNext;
    fifoEntry_t    pushEntry;
    fifoEntry_t    headEntry;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [CW-1:0] fifoCount;
    logic          ovfReg;
    logic [7:0]    ovfCnt;
    logic [31:0]   statusWord;

    assign ramSel    = !dmemAddr[31];
    assign ramIdx    = dmemAddr[AW+1:2];
    assign statusSel = (dmemAddr == MMIO_BASE);
    assign clrStore  = dmemWen && statusSel;
    assign pushReq   = dmemWen && dmemAddr[31] && !statusSel;
    assign pop       = busReqInt && bus.busAck;
    assign pushOk    = pushReq && (!fifoFull || pop);
    assign drop      = pushReq && !pushOk;
    assign pushEntry = '{addr: dmemAddr, data: dmemWdata};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifoEntry_t))
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (pushOk),
        .pop   (pop),
        .din   (pushEntry),
        .dout  (headEntry),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    assign bus.busReq  = busReqInt;
    assign bus.busAddr = headEntry.addr;
    assign bus.busData = headEntry.data;
    assign ovf         = ovfReg;

    // Local RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (dmemWen && ramSel) ramMem[ramIdx] <= dmemWdata;
    end

    // Bus FSM state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) stateReg <= IDLE;
        else       stateReg <= stateNext;
    end

    // Bus FSM: request while entries remain; drop back only when the last one leaves.
    always_comb begin
        stateNext = stateReg;
        busReqInt = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!fifoEmpty) stateNext = REQ;
            end
            REQ: begin
                busReqInt = 1'b1;
                if (bus.busAck && (fifoCount == CW'(1)) && !pushOk) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sticky overflow flag; a clear store has priority over a drop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)         ovfReg <= 1'b0;
        else if (clrStore) ovfReg <= 1'b0;
        else if (drop)     ovfReg <= 1'b1;
    end

`ifdef DMEM_BRIDGE_OVFCNT_EN
    logic [7:0] ovfCntReg;

    // Saturating count of dropped posted stores.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)                             ovfCntReg <= '0;
        else if (clrStore)                     ovfCntReg <= '0;
        else if (drop && ovfCntReg != OVFCNT_MAX) ovfCntReg <= ovfCntReg + 1'b1;
    end

    assign ovfCnt = ovfCntReg;
`else
    assign ovfCnt = 8'h00;
`endif

    // Status register image.
    always_comb begin
        statusWord                                  = '0;
        statusWord[ST_EMPTY]                        = fifoEmpty;
        statusWord[ST_FULL]                         = fifoFull;
        statusWord[ST_BUSREQ]                       = busReqInt;
        statusWord[ST_COUNT_LSB+3:ST_COUNT_LSB]     = 4'(fifoCount);
        statusWord[ST_OVFCNT_LSB+7:ST_OVFCNT_LSB]   = ovfCnt;
    end

    // Load mux: RAM read is asynchronous so a same-cycle store is not yet visible.
    always_comb begin
        dmemRdata = '0;
        if (ramSel)         dmemRdata = ramMem[ramIdx];
        else if (statusSel) dmemRdata = statusWord;
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scenarios plus randomized traffic, compared
// against a queue-based reference model of the bridge.
module tb_dmem_bridge;
    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        dmemWen;
    logic [31:0] dmemRdata;
    logic        ovf;

    dmem_bridge_if bus ();

    dmem_bridge #(
        .RAM_WORDS  (1024),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .dmemAddr  (dmemAddr),
        .dmemWdata (dmemWdata),
        .dmemWen   (dmemWen),
        .dmemRdata (dmemRdata),
        .bus       (bus),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t        q[$];
    logic [31:0] ramModel [1024];
    bit          ramValid [1024];
    int          prevCnt;
    bit          ovfM;
    int          cntM;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] expStatus(input bit req);
        logic [31:0] s;
        s       = '0;
        s[0]    = (q.size() == 0);
        s[1]    = (q.size() == DEPTH);
        s[2]    = req;
        s[7:4]  = 4'(q.size());
`ifdef DMEM_BRIDGE_OVFCNT_EN
        s[15:8] = 8'(cntM);
`endif
        return s;
    endfunction

    function automatic logic [31:0] randAddr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 5)
            a = {1'b0, 19'($urandom), 6'b0, 4'($urandom), 2'($urandom)};
        else if (r < 6)
            a = BASE;
        else
            a = BASE | ($urandom_range(1, 32'h3FF) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d, input bit ack);
        bit expReq, pop, clr, pushReq, accept;
        int idx;
        @(negedge clk);
        dmemWen    = we;
        dmemAddr   = a;
        dmemWdata  = d;
        bus.busAck = ack;
        #1;
        // An entry is requested once it has been queued across a full clock.
        expReq = (prevCnt > 0) && (q.size() > 0);
        chk("busReq", 32'(bus.busReq), 32'(expReq));
        if (expReq) begin
            chk("busAddr", bus.busAddr, q[0].a);
            chk("busData", bus.busData, q[0].d);
        end
        chk("ovf", 32'(ovf), 32'(ovfM));
        idx = int'(a[11:2]);
        if (!a[31]) begin
            if (ramValid[idx]) chk("ramRd", dmemRdata, ramModel[idx]);
        end else if (a == BASE) begin
            chk("status", dmemRdata, expStatus(expReq));
        end else begin
            chk("mmioRd", dmemRdata, 32'h0);
        end
        pop     = expReq && ack;
        clr     = we && (a == BASE);
        pushReq = we && a[31] && !clr;
        accept  = pushReq && ((q.size() < DEPTH) || pop);
        if (we && !a[31]) begin
            ramModel[idx] = d;
            ramValid[idx] = 1'b1;
        end
        prevCnt = q.size();
        if (pop) begin
            $display("xfer addr=%h data=%h", q[0].a, q[0].d);
            void'(q.pop_front());
        end
        if (accept) q.push_back('{a: a, d: d});
        if (clr) begin
            ovfM = 1'b0;
            cntM = 0;
        end else if (pushReq && !accept) begin
            ovfM = 1'b1;
            if (cntM < 255) cntM++;
        end
        @(posedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        dmemWen    = 1'b0;
        bus.busAck = 1'b0;
        rstN       = 1'b0;
        #1;
        chk("rstBusReq", 32'(bus.busReq), 32'h0);
        chk("rstBusAddr", bus.busAddr, 32'h0);
        chk("rstBusData", bus.busData, 32'h0);
        chk("rstOvf", 32'(ovf), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        q.delete();
        prevCnt = 0;
        ovfM    = 1'b0;
        cntM    = 0;
        $display("reset applied");
    endtask

    initial begin
        int ackProb;
        checks     = 0;
        failures   = 0;
        rstN       = 1'b0;
        dmemWen    = 1'b0;
        dmemAddr   = '0;
        dmemWdata  = '0;
        bus.busAck = 1'b0;
        prevCnt    = 0;
        ovfM       = 1'b0;
        cntM       = 0;
        for (int i = 0; i < 1024; i++) ramValid[i] = 1'b0;
        doReset();

        // RAM store/load, no bus activity.
        cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        cycle(1'b0, 32'h0000_0013, 32'h0, 1'b0);

        // Single posted write with ack held high.
        cycle(1'b1, 32'h8000_0040, 32'h55, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, BASE, 32'h0, 1'b1);

        // Six stores with no ack: fill then overflow twice.
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h8000_0100 + 32'(i * 4), 32'(i), 1'b0);
        cycle(1'b0, BASE, 32'h0, 1'b0);

        // Full FIFO with pop and push together.
        cycle(1'b1, 32'h8000_0200, 32'hA5A5_0001, 1'b1);
        cycle(1'b0, BASE, 32'h0, 1'b0);

        // Clear after overflow leaves FIFO contents alone.
        cycle(1'b1, BASE, 32'h0, 1'b0);
        cycle(1'b0, BASE, 32'h0, 1'b0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h8000_0300 + 32'(i * 4), 32'(i + 16), 1'b0);
        cycle(1'b0, BASE, 32'h0, 1'b0);
        doReset();
        cycle(1'b0, BASE, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic with alternating bus back-pressure.
        for (int i = 0; i < 1500; i++) begin
            ackProb = (((i / 100) % 2) != 0) ? 85 : 25;
            if ($urandom_range(0, 499) == 0)
                doReset();
            else
                cycle($urandom_range(0, 99) < 70, randAddr(), $urandom,
                      $urandom_range(0, 99) < ackProb);
        end

        // Overflow counter saturation, then clear.
        for (int i = 0; i < 270; i++) cycle(1'b1, 32'h8000_0400, 32'(i), 1'b0);
        cycle(1'b0, BASE, 32'h0, 1'b0);
        cycle(1'b1, BASE, 32'h0, 1'b0);
        cycle(1'b0, BASE, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, BASE, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
